neuron_engine_apb: RTL

NEURON_ENGINE_APB -- requirements
Module: neuron_engine_apb

---
 rtl/neuron_engine_apb_if.sv | 19 +
 rtl/neuron_engine_apb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_engine_apb_if.sv
// APB bundle between a bus master and the neuron engine register/RAM slave.
interface neuron_engine_apb_if #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12
);
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [Amba_Addr_Depth-1:0] PADDR;
    logic [Amba_Word-1:0]       PWDATA;
    logic [Amba_Word-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/neuron_engine_apb.sv
// Single-neuron classifier: APB-loaded pixel/weight RAMs, two-stage MAC pipeline,
// bias compare in EVAL; result, status and interrupt exposed over APB.
module neuron_engine_apb #(
    parameter int Amba_Word        = 24,
    parameter int Amba_Addr_Depth  = 12,
    parameter int Channels         = 3,
    parameter int Weight_Precision = 5,
    parameter int Num_Words        = 1024
) (
    input  logic               clk,
    input  logic               rst,
    neuron_engine_apb_if.slave apb,
    output logic               CatRecOut,
    output logic               irq
);
    localparam int IDX_W  = Amba_Addr_Depth - 2;
    localparam int CNT_W  = (Num_Words > 1) ? $clog2(Num_Words) : 1;
    localparam int WRAM_W = Channels * Weight_Precision;
    localparam int PROD_W = Weight_Precision + 9;
    localparam int ACC_W  = 8 + Weight_Precision + $clog2(Num_Words * Channels) + 1;
    localparam int SUM_W  = ((ACC_W > Amba_Word) ? ACC_W : Amba_Word) + 1;

    localparam logic [IDX_W:0]   NUM_WORDS_L = (IDX_W + 1)'(Num_Words);
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(Num_Words - 1);
    localparam logic [1:0] RG_REG = 2'b00;
    localparam logic [1:0] RG_PIX = 2'b01;
    localparam logic [1:0] RG_WGT = 2'b10;
    localparam logic [1:0] RG_RSV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EVAL} state_t;

    // One word's contribution: signed weight lanes times unsigned pixel lanes.
    function automatic logic signed [ACC_W-1:0] mac_word(input logic [Amba_Word-1:0] pix,
                                                         input logic [WRAM_W-1:0]    wgt);
        logic signed [ACC_W-1:0]  s;
        logic signed [PROD_W-1:0] wt;
        logic signed [PROD_W-1:0] px;
        s = '0;
        for (int c = 0; c < Channels; c++) begin
            wt = PROD_W'($signed(wgt[c*Weight_Precision +: Weight_Precision]));
            px = PROD_W'({1'b0, pix[c*8 +: 8]});
            s  = s + ACC_W'(wt * px);
        end
        return s;
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_acc(input logic signed [ACC_W-1:0] a);
        return SUM_W'(a);
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_bias(input logic [Amba_Word-1:0] b);
        return SUM_W'($signed(b));
    endfunction

    state_t r_state;
    state_t w_next;

    logic [Amba_Word-1:0] r_pix_mem [Num_Words];
    logic [WRAM_W-1:0]    r_wgt_mem [Num_Words];

    logic [1:0]           w_region;
    logic [IDX_W-1:0]     w_idx;
    logic [CNT_W-1:0]     w_ram_idx;
    logic                 w_setup, w_access, w_in_ram, w_oor;
    logic                 w_err_addr, w_err_wr, w_err, w_wr_ok, w_rd_setup;
    logic                 w_wr_ctrl, w_wr_status, w_wr_bias, w_wr_pix, w_wr_wgt, w_start;
    logic                 w_busy, w_issue, w_eval;
    logic [Amba_Word-1:0] w_rdval;
    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_sum;

    logic                 r_irq_en, r_done, r_result, r_drain;
    logic [Amba_Word-1:0] r_bias, r_acc_reg, r_prdata;
    logic [CNT_W-1:0]     r_rd_idx;
    logic [Amba_Word-1:0] r_pix_p0;
    logic [WRAM_W-1:0]    r_wgt_p0;
    logic                 r_vld_p0;
    logic signed [ACC_W-1:0] r_acc_p1;

    assign w_region  = apb.PADDR[Amba_Addr_Depth-1 -: 2];
    assign w_idx     = apb.PADDR[IDX_W-1:0];
    assign w_ram_idx = w_idx[CNT_W-1:0];

    assign w_setup    = apb.PSEL & ~apb.PENABLE;
    assign w_access   = apb.PSEL &  apb.PENABLE;
    assign w_in_ram   = (w_region == RG_PIX) | (w_region == RG_WGT);
    assign w_oor      = w_in_ram & ({1'b0, w_idx} >= NUM_WORDS_L);
    assign w_err_addr = (w_region == RG_RSV) | w_oor;
    // ACC is read-only; RAMs are frozen while the engine streams them.
    assign w_err_wr   = apb.PWRITE & ((w_in_ram & w_busy) |
                                      ((w_region == RG_REG) & (w_idx == IDX_W'(3))));
    assign w_err      = w_err_addr | w_err_wr;
    assign w_wr_ok    = w_access & apb.PWRITE & ~w_err;
    assign w_rd_setup = w_setup & ~apb.PWRITE;

    assign w_wr_ctrl   = w_wr_ok & (w_region == RG_REG) & (w_idx == IDX_W'(0));
    assign w_wr_status = w_wr_ok & (w_region == RG_REG) & (w_idx == IDX_W'(1));
    assign w_wr_bias   = w_wr_ok & (w_region == RG_REG) & (w_idx == IDX_W'(2));
    assign w_wr_pix    = w_wr_ok & (w_region == RG_PIX);
    assign w_wr_wgt    = w_wr_ok & (w_region == RG_WGT);
    assign w_start     = w_wr_ctrl & apb.PWDATA[0] & ~w_busy;

    assign apb.PSLVERR = w_access & w_err;
    assign apb.PREADY  = 1'b1;
    assign apb.PRDATA  = r_prdata;
    assign CatRecOut   = r_result;
    assign irq         = r_done & r_irq_en;

    always_comb begin
        w_rdval = '0;
        case (w_region)
            RG_REG: begin
                if (w_idx == IDX_W'(0))      w_rdval = Amba_Word'({r_irq_en, 1'b0});
                else if (w_idx == IDX_W'(1)) w_rdval = Amba_Word'({r_result, r_done, w_busy});
                else if (w_idx == IDX_W'(2)) w_rdval = r_bias;
                else if (w_idx == IDX_W'(3)) w_rdval = r_acc_reg;
            end
            RG_PIX:  if (!w_oor) w_rdval = r_pix_mem[w_ram_idx];
            RG_WGT:  if (!w_oor) w_rdval = Amba_Word'(r_wgt_mem[w_ram_idx]);
            default: w_rdval = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (r_rd_idx == LAST_IDX) w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_EVAL;
            S_EVAL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != S_IDLE);
        w_issue = (r_state == S_RUN);
        w_eval  = (r_state == S_EVAL);
    end

    // p0: synchronous RAM read of the word addressed by the run counter
    always_ff @(posedge clk) begin
        if (w_wr_pix) r_pix_mem[w_ram_idx] <= apb.PWDATA;
        if (w_wr_wgt) r_wgt_mem[w_ram_idx] <= apb.PWDATA[WRAM_W-1:0];
        if (w_issue) begin
            r_pix_p0 <= r_pix_mem[r_rd_idx];
            r_wgt_p0 <= r_wgt_mem[r_rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain  <= 1'b0;
            r_rd_idx <= '0;
            r_vld_p0 <= 1'b0;
            r_irq_en <= 1'b0;
            r_bias   <= '0;
        end else begin
            r_drain  <= (r_state == S_DRAIN) & ~r_drain;
            r_vld_p0 <= w_issue;
            if (w_start)      r_rd_idx <= '0;
            else if (w_issue) r_rd_idx <= r_rd_idx + CNT_W'(1);
            if (w_wr_ctrl) r_irq_en <= apb.PWDATA[1];
            if (w_wr_bias) r_bias   <= apb.PWDATA;
        end
    end

    // p1: accumulate; width is sized so the full-scale sum can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_acc_p1 <= '0;
        else if (w_start)  r_acc_p1 <= '0;
        else if (r_vld_p0) r_acc_p1 <= r_acc_p1 + mac_word(r_pix_p0, r_wgt_p0);
    end

    assign w_acc_ext = ext_acc(r_acc_p1);
    assign w_sum     = w_acc_ext + ext_bias(r_bias);

    // EVAL wins over a same-cycle done-clear so a finished result is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_result  <= 1'b0;
            r_acc_reg <= '0;
            r_prdata  <= '0;
        end else begin
            if (w_eval) begin
                r_done    <= 1'b1;
                r_result  <= ~w_sum[SUM_W-1] & (w_sum != '0);
                r_acc_reg <= w_acc_ext[Amba_Word-1:0];
            end else if (w_start | (w_wr_status & apb.PWDATA[1])) begin
                r_done <= 1'b0;
            end
            if (w_rd_setup) r_prdata <= w_err_addr ? '0 : w_rdval;
        end
    end
endmodule
